mmu_sfr_write_arbiter: RTL and testbench
========================================

# mmu_sfr_write_arbiter

Arbitrates SFR write requests from several MMU-side requesters (e.g. processor pipe, refill engine, debug path) onto the single processor SFR write port. That port carries cmd/en/idx/val with commands SET=00, HFXB=01, HFXT=10, RES=11. The arbiter is round-robin with a half-word lock: an HFXB write locks the port to its requester until the matching HFXT, or until a timeout. All port outputs are registered, one write per cycle.

## Interface
- NUM_REQ, 2, number of requesters (2..4)
- LOCK_TIMEOUT, 16, max consecutive owner-idle cycles held in LOCKED (≥2)
- clock  in  1  clock, rising edge
- reset  in  1  asynchronous, active-high
- req_valid_i  in  NUM_REQ  request k valid
- req_ready_o  out  NUM_REQ  grant to k this cycle (combinational)
- req_cmd_i  in  2*NUM_REQ  cmd of k at [2k+1:2k]
- req_idx_i  in  8*NUM_REQ  idx of k at [8k+7:8k]
- req_val_i  in  32*NUM_REQ  value of k at [32k+31:32k]
- cpu_wr_reg_en_i_m  out  1  write strobe to SFR port
- cpu_wr_reg_cmd_i_m  out  2  command
- cpu_wr_reg_idx_i_m  out  8  register index
- cpu_wr_reg_val_i_m  out  32  write data
- lock_active_o  out  1  arbiter in LOCKED
- lock_owner_o  out  2  owner when locked, else 0
- lock_err_o  out  1  1-cycle pulse: owner sent HFXT with wrong idx
- lock_timeout_o  out  1  1-cycle pulse: lock released by timeout
- wr_count_o  out  16  issued-write counter

## Operation
- Accept for k = req_valid_i[k] & req_ready_o[k]. At most one ready bit set per cycle. SFR port never back-pressures.
- IDLE: eligible = all valid requesters. Grant the first valid at or after rr_ptr, with circular search. After a grant to k, rr_ptr ← (k+1) mod NUM_REQ.
- LOCKED: only lock_owner is eligible. Other requesters get ready=0. rr_ptr still updates on owner grants.
- FSM transitions on an accepted cmd:
  - IDLE + HFXB → LOCKED, with owner ← k and lock_idx ← idx.
  - LOCKED + owner HFXT, idx == lock_idx → IDLE.
  - LOCKED + owner HFXT, idx != lock_idx → write still issued, stay LOCKED, lock_err_o pulses next cycle.
  - LOCKED + owner HFXB → lock_idx ← new idx, stay LOCKED.
  - LOCKED + owner SET/RES → issued, stay LOCKED.
  - IDLE + HFXT/SET/RES → issued, stay IDLE. An orphan HFXT is not an error.
- Timeout counter tmo_cnt:
  - Cleared on entering LOCKED and on every owner accept.
  - Increments each LOCKED cycle with no owner accept.
  - If tmo_cnt == LOCK_TIMEOUT-1 and there is no accept this cycle → IDLE at next edge, and lock_timeout_o = 1 in the following cycle.
- Simultaneous events: an owner accept in the terminal timeout cycle wins, so there is no timeout and the counter is cleared. A matching HFXT at timeout releases normally, with no timeout pulse.
- wr_count_o increments per issued write, wrapping 0xFFFF→0x0000.
- Widths: lock_owner_o zero-extended to 2 bits. NUM_REQ=1 is not supported.

## Timing
- Latency: accept at edge N → cpu_wr_reg_en_i_m=1 with the captured cmd/idx/val during cycle N+1. Back-to-back accepts give a strobe every cycle.
- cmd/idx/val hold their last value when en=0.
- lock_active_o / lock_owner_o are registered and reflect state after the edge. The cycle after the HFXB accept shows lock_active_o=1.
- req_ready_o depends combinationally on req_valid_i, state and rr_ptr. There is no combinational path from req_cmd_i/idx/val to ready.
- Reset (async, any time, including mid-lock) gives:
  - en=0, cmd=SET(00), idx=0, val=0;
  - lock_active_o=0, lock_owner_o=0, lock_err_o=0, lock_timeout_o=0, wr_count_o=0;
  - state IDLE, rr_ptr=0, tmo_cnt=0.
- No write is issued in the cycle after reset deassertion unless an accept occurred at that edge.

## Test plan
- Round-robin: NUM_REQ=2, both valid continuously with SET idx 0x10/0x20 → grants alternate 0,1,0,1. Port shows idx 0x10,0x20,… one per cycle. wr_count_o=4 after 4 writes.
- Lock hold-off: req0 HFXB idx 0x05, req1 valid throughout, req0 HFXT idx 0x05 three cycles later → req1 ready=0 until the HFXT accept. Then IDLE, req1 granted the next cycle, lock_active_o low.
- Wrong-idx HFXT: lock on idx 0x05, owner HFXT idx 0x06 → write issued, lock_err_o pulses once, still locked. HFXT 0x05 then releases.
- Timeout: LOCK_TIMEOUT=16, owner idle after HFXB → exactly 16 idle LOCKED cycles. Then IDLE, lock_timeout_o one-cycle pulse, and req1 is granted.
- Race at timeout: owner asserts SET in terminal cycle 15 → accepted, no timeout pulse, tmo_cnt restarts.
- Reset mid-lock and counter wrap:
  - Assert reset while LOCKED with writes in flight → all outputs return to reset values immediately. The first post-reset grant goes to req0.
  - Preload 0xFFFF writes, then one more → wr_count_o=0x0000.

Source files
------------

// File: rtl/mmu_sfr_write_arbiter.sv
// Round-robin arbiter for MMU-side SFR write requesters onto the single CPU SFR write port.
// An HFXB write locks the port to its requester until the matching HFXT or an idle timeout.
module mmu_sfr_write_arbiter #(
    parameter int unsigned NUM_REQ      = 2,
    parameter int unsigned LOCK_TIMEOUT = 16
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic [NUM_REQ-1:0]      req_valid_i,
    output logic [NUM_REQ-1:0]      req_ready_o,
    input  logic [2*NUM_REQ-1:0]    req_cmd_i,
    input  logic [8*NUM_REQ-1:0]    req_idx_i,
    input  logic [32*NUM_REQ-1:0]   req_val_i,
    output logic                    cpu_wr_reg_en_i_m,
    output logic [1:0]              cpu_wr_reg_cmd_i_m,
    output logic [7:0]              cpu_wr_reg_idx_i_m,
    output logic [31:0]             cpu_wr_reg_val_i_m,
    output logic                    lock_active_o,
    output logic [1:0]              lock_owner_o,
    output logic                    lock_err_o,
    output logic                    lock_timeout_o,
    output logic [15:0]             wr_count_o
);

    localparam int unsigned TMO_W = (LOCK_TIMEOUT > 2) ? $clog2(LOCK_TIMEOUT) : 1;

    localparam logic [1:0] CMD_HFXB = 2'b01;
    localparam logic [1:0] CMD_HFXT = 2'b10;

    typedef enum logic {
        S_IDLE   = 1'b0,
        S_LOCKED = 1'b1
    } state_t;

    state_t             state;
    logic [1:0]         rr_ptr;
    logic [1:0]         owner;
    logic [7:0]         lock_idx;
    logic [TMO_W-1:0]   tmo_cnt;

    logic [NUM_REQ-1:0] grant;
    logic [1:0]         gnt_id;
    logic               found;
    logic               accept;
    logic [1:0]         sel_cmd;
    logic [7:0]         sel_idx;
    logic [31:0]        sel_val;

    // Grant selection: owner only while locked, otherwise first valid at or after rr_ptr.
    always_comb begin
        grant  = '0;
        gnt_id = '0;
        found  = 1'b0;
        if (state == S_LOCKED) begin
            gnt_id = owner;
            for (int k = 0; k < NUM_REQ; k++) begin
                if ((2'(k) == owner) && req_valid_i[k]) begin
                    grant[k] = 1'b1;
                end
            end
        end else begin
            for (int k = 0; k < NUM_REQ; k++) begin
                if (!found && req_valid_i[k] && (k >= int'(rr_ptr))) begin
                    grant[k] = 1'b1;
                    gnt_id   = 2'(k);
                    found    = 1'b1;
                end
            end
            for (int k = 0; k < NUM_REQ; k++) begin
                if (!found && req_valid_i[k]) begin
                    grant[k] = 1'b1;
                    gnt_id   = 2'(k);
                    found    = 1'b1;
                end
            end
        end
    end

    assign accept      = |grant;
    assign req_ready_o = grant;

    // Payload mux driven by the one-hot grant.
    always_comb begin
        sel_cmd = '0;
        sel_idx = '0;
        sel_val = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (grant[k]) begin
                sel_cmd = req_cmd_i[2*k +: 2];
                sel_idx = req_idx_i[8*k +: 8];
                sel_val = req_val_i[32*k +: 32];
            end
        end
    end

    assign lock_active_o = (state == S_LOCKED);
    assign lock_owner_o  = owner;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state              <= S_IDLE;
            rr_ptr             <= '0;
            owner              <= '0;
            lock_idx           <= '0;
            tmo_cnt            <= '0;
            cpu_wr_reg_en_i_m  <= 1'b0;
            cpu_wr_reg_cmd_i_m <= '0;
            cpu_wr_reg_idx_i_m <= '0;
            cpu_wr_reg_val_i_m <= '0;
            lock_err_o         <= 1'b0;
            lock_timeout_o     <= 1'b0;
            wr_count_o         <= '0;
        end else begin
            cpu_wr_reg_en_i_m <= accept;
            lock_err_o        <= 1'b0;
            lock_timeout_o    <= 1'b0;

            if (accept) begin
                cpu_wr_reg_cmd_i_m <= sel_cmd;
                cpu_wr_reg_idx_i_m <= sel_idx;
                cpu_wr_reg_val_i_m <= sel_val;
                wr_count_o         <= wr_count_o + 16'd1;
                rr_ptr             <= (gnt_id == 2'(NUM_REQ - 1)) ? 2'd0 : gnt_id + 2'd1;
            end

            case (state)
                S_IDLE: begin
                    if (accept && (sel_cmd == CMD_HFXB)) begin
                        state    <= S_LOCKED;
                        owner    <= gnt_id;
                        lock_idx <= sel_idx;
                        tmo_cnt  <= '0;
                    end
                end
                S_LOCKED: begin
                    if (accept) begin
                        // Any owner write restarts the idle timer, even in the terminal cycle.
                        tmo_cnt <= '0;
                        if (sel_cmd == CMD_HFXT) begin
                            if (sel_idx == lock_idx) begin
                                state <= S_IDLE;
                                owner <= '0;
                            end else begin
                                lock_err_o <= 1'b1;
                            end
                        end else if (sel_cmd == CMD_HFXB) begin
                            lock_idx <= sel_idx;
                        end
                    end else if (tmo_cnt == TMO_W'(LOCK_TIMEOUT - 1)) begin
                        state          <= S_IDLE;
                        owner          <= '0;
                        tmo_cnt        <= '0;
                        lock_timeout_o <= 1'b1;
                    end else begin
                        tmo_cnt <= tmo_cnt + TMO_W'(1);
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mmu_sfr_write_arbiter.sv
// Bench for mmu_sfr_write_arbiter: directed scenarios, a queue-free behavioural model
// compared every cycle, and literal checks at the key points of each scenario.
module tb_mmu_sfr_write_arbiter;

    localparam int NR  = 2;
    localparam int TMO = 16;

    localparam logic [1:0] SET  = 2'b00;
    localparam logic [1:0] HFXB = 2'b01;
    localparam logic [1:0] HFXT = 2'b10;

    logic               clock = 1'b0;
    logic               reset = 1'b1;
    logic [NR-1:0]      req_valid;
    logic [NR-1:0]      req_ready;
    logic [2*NR-1:0]    req_cmd;
    logic [8*NR-1:0]    req_idx;
    logic [32*NR-1:0]   req_val;
    logic               wr_en;
    logic [1:0]         wr_cmd;
    logic [7:0]         wr_idx;
    logic [31:0]        wr_val;
    logic               lock_active;
    logic [1:0]         lock_owner;
    logic               lock_err;
    logic               lock_timeout;
    logic [15:0]        wr_count;

    logic               valid_a [NR];
    logic [1:0]         cmd_a   [NR];
    logic [7:0]         idx_a   [NR];
    logic [31:0]        val_a   [NR];

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clock = ~clock;

    always_comb begin
        req_valid = '0;
        req_cmd   = '0;
        req_idx   = '0;
        req_val   = '0;
        for (int k = 0; k < NR; k++) begin
            req_valid[k]         = valid_a[k];
            req_cmd[2*k +: 2]    = cmd_a[k];
            req_idx[8*k +: 8]    = idx_a[k];
            req_val[32*k +: 32]  = val_a[k];
        end
    end

    mmu_sfr_write_arbiter #(.NUM_REQ(NR), .LOCK_TIMEOUT(TMO)) dut (
        .clock              (clock),
        .reset              (reset),
        .req_valid_i        (req_valid),
        .req_ready_o        (req_ready),
        .req_cmd_i          (req_cmd),
        .req_idx_i          (req_idx),
        .req_val_i          (req_val),
        .cpu_wr_reg_en_i_m  (wr_en),
        .cpu_wr_reg_cmd_i_m (wr_cmd),
        .cpu_wr_reg_idx_i_m (wr_idx),
        .cpu_wr_reg_val_i_m (wr_val),
        .lock_active_o      (lock_active),
        .lock_owner_o       (lock_owner),
        .lock_err_o         (lock_err),
        .lock_timeout_o     (lock_timeout),
        .wr_count_o         (wr_count)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Behavioural model: who may write, what the port shows, lock bookkeeping.
    bit          m_locked;
    int          m_owner;
    logic [7:0]  m_lidx;
    int          m_idle;
    int          m_rr;
    logic        e_en;
    logic [1:0]  e_cmd;
    logic [7:0]  e_idx;
    logic [31:0] e_val;
    logic [15:0] e_cnt;
    logic        e_err;
    logic        e_tmo;

    function automatic int pick();
        if (m_locked) return valid_a[m_owner] ? m_owner : -1;
        for (int i = 0; i < NR; i++) begin
            if (valid_a[(m_rr + i) % NR]) return (m_rr + i) % NR;
        end
        return -1;
    endfunction

    always @(posedge clock or posedge reset) begin
        int g;
        if (reset) begin
            m_locked <= 1'b0; m_owner <= 0; m_lidx <= '0; m_idle <= 0; m_rr <= 0;
            e_en <= 1'b0; e_cmd <= '0; e_idx <= '0; e_val <= '0;
            e_cnt <= '0; e_err <= 1'b0; e_tmo <= 1'b0;
        end else begin
            g = pick();
            e_en  <= (g >= 0);
            e_err <= 1'b0;
            e_tmo <= 1'b0;
            if (g >= 0) begin
                e_cmd <= cmd_a[g];
                e_idx <= idx_a[g];
                e_val <= val_a[g];
                e_cnt <= e_cnt + 16'd1;
                m_rr  <= (g + 1) % NR;
            end
            if (!m_locked) begin
                if (g >= 0 && cmd_a[g] == HFXB) begin
                    m_locked <= 1'b1; m_owner <= g; m_lidx <= idx_a[g]; m_idle <= 0;
                end
            end else if (g >= 0) begin
                m_idle <= 0;
                if (cmd_a[g] == HFXT) begin
                    if (idx_a[g] == m_lidx) m_locked <= 1'b0;
                    else e_err <= 1'b1;
                end else if (cmd_a[g] == HFXB) begin
                    m_lidx <= idx_a[g];
                end
            end else if (m_idle + 1 == TMO) begin
                m_locked <= 1'b0; m_idle <= 0; e_tmo <= 1'b1;
            end else begin
                m_idle <= m_idle + 1;
            end
        end
    end

    always @(negedge clock) begin
        int g;
        logic [NR-1:0] r;
        if (!reset) begin
            g = pick();
            r = '0;
            if (g >= 0) r[g] = 1'b1;
            chk("ready", 32'(req_ready), 32'(r));
            chk("en", 32'(wr_en), 32'(e_en));
            chk("cmd", 32'(wr_cmd), 32'(e_cmd));
            chk("idx", 32'(wr_idx), 32'(e_idx));
            chk("val", wr_val, e_val);
            chk("lock_active", 32'(lock_active), 32'(m_locked));
            chk("lock_owner", 32'(lock_owner), m_locked ? 32'(m_owner) : 32'd0);
            chk("lock_err", 32'(lock_err), 32'(e_err));
            chk("lock_timeout", 32'(lock_timeout), 32'(e_tmo));
            chk("wr_count", 32'(wr_count), 32'(e_cnt));
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic set_req(input int k, input logic v, input logic [1:0] c, input logic [7:0] i);
        valid_a[k] = v;
        cmd_a[k]   = c;
        idx_a[k]   = i;
        val_a[k]   = {8'hC0, 8'(k), 8'h5A, i};
    endtask

    task automatic idle_all();
        for (int k = 0; k < NR; k++) set_req(k, 1'b0, SET, 8'h00);
    endtask

    initial begin
        idle_all();
        repeat (3) tick();
        reset = 1'b0;
        #1;
        chk("rst_en", 32'(wr_en), 32'd0);
        chk("rst_count", 32'(wr_count), 32'd0);
        chk("rst_lock", 32'(lock_active), 32'd0);

        // Round-robin between two always-valid requesters.
        set_req(0, 1'b1, SET, 8'h10);
        set_req(1, 1'b1, SET, 8'h20);
        tick(); chk("rr_idx0", 32'(wr_idx), 32'h10);
        tick(); chk("rr_idx1", 32'(wr_idx), 32'h20);
        tick(); chk("rr_idx2", 32'(wr_idx), 32'h10);
        tick(); chk("rr_idx3", 32'(wr_idx), 32'h20);
        chk("rr_count", 32'(wr_count), 32'd4);
        chk("model_count", 32'(e_cnt), 32'd4);
        idle_all();
        tick(); chk("hold_en", 32'(wr_en), 32'd0);
        chk("hold_idx", 32'(wr_idx), 32'h20);

        // Lock hold-off: req1 is starved until the owner's matching HFXT.
        set_req(0, 1'b1, HFXB, 8'h05);
        set_req(1, 1'b1, SET, 8'h20);
        #1; chk("lk_ready_pre", 32'(req_ready), 32'b01);
        tick(); chk("lk_active", 32'(lock_active), 32'd1);
        chk("lk_cmd", 32'(wr_cmd), 32'(HFXB));
        set_req(0, 1'b0, SET, 8'h00);
        #1; chk("lk_ready_blk", 32'(req_ready), 32'b00);
        tick(); tick();
        set_req(0, 1'b1, HFXT, 8'h05);
        #1; chk("lk_ready_own", 32'(req_ready), 32'b01);
        tick(); chk("lk_release", 32'(lock_active), 32'd0);
        set_req(0, 1'b0, SET, 8'h00);
        #1; chk("lk_ready_r1", 32'(req_ready), 32'b10);
        tick(); chk("lk_r1_idx", 32'(wr_idx), 32'h20);
        idle_all();
        tick();

        // Wrong-index HFXT: write issued, one error pulse, lock held.
        set_req(0, 1'b1, HFXB, 8'h05);
        tick();
        set_req(0, 1'b1, HFXT, 8'h06);
        tick(); chk("we_err", 32'(lock_err), 32'd1);
        chk("we_en", 32'(wr_en), 32'd1);
        chk("we_locked", 32'(lock_active), 32'd1);
        set_req(0, 1'b0, SET, 8'h00);
        tick(); chk("we_err_once", 32'(lock_err), 32'd0);
        set_req(0, 1'b1, HFXT, 8'h05);
        tick(); chk("we_release", 32'(lock_active), 32'd0);
        idle_all();
        tick();

        // Timeout after exactly TMO idle locked cycles, then req1 gets through.
        set_req(0, 1'b1, HFXB, 8'h07);
        tick();
        set_req(0, 1'b0, SET, 8'h00);
        set_req(1, 1'b1, SET, 8'h33);
        repeat (TMO - 1) tick();
        chk("to_still_locked", 32'(lock_active), 32'd1);
        chk("to_no_pulse", 32'(lock_timeout), 32'd0);
        tick(); chk("to_released", 32'(lock_active), 32'd0);
        chk("to_pulse", 32'(lock_timeout), 32'd1);
        tick(); chk("to_pulse_end", 32'(lock_timeout), 32'd0);
        chk("to_r1_idx", 32'(wr_idx), 32'h33);
        idle_all();
        tick();

        // Owner write in the terminal cycle beats the timeout and restarts the count.
        set_req(0, 1'b1, HFXB, 8'h08);
        tick();
        set_req(0, 1'b0, SET, 8'h00);
        repeat (TMO - 1) tick();
        set_req(0, 1'b1, SET, 8'h09);
        tick(); chk("race_locked", 32'(lock_active), 32'd1);
        chk("race_no_pulse", 32'(lock_timeout), 32'd0);
        chk("race_idx", 32'(wr_idx), 32'h09);
        set_req(0, 1'b0, SET, 8'h00);
        repeat (TMO - 1) tick();
        chk("race_restart", 32'(lock_active), 32'd1);
        tick(); chk("race_timeout", 32'(lock_timeout), 32'd1);
        idle_all();
        tick();

        // Asynchronous reset in the middle of a lock with a write in flight.
        set_req(0, 1'b1, HFXB, 8'h0A);
        tick();
        set_req(0, 1'b1, SET, 8'h0B);
        set_req(1, 1'b1, SET, 8'h44);
        tick(); chk("mr_inflight", 32'(wr_en), 32'd1);
        reset = 1'b1;
        #1;
        chk("mr_en", 32'(wr_en), 32'd0);
        chk("mr_idx", 32'(wr_idx), 32'd0);
        chk("mr_val", wr_val, 32'd0);
        chk("mr_lock", 32'(lock_active), 32'd0);
        chk("mr_count", 32'(wr_count), 32'd0);
        tick();
        reset = 1'b0;
        #1; chk("mr_ready", 32'(req_ready), 32'b01);
        tick(); chk("mr_first_idx", 32'(wr_idx), 32'h0B);
        chk("mr_first_cnt", 32'(wr_count), 32'd1);

        // Stream until the write counter wraps.
        repeat (65534) tick();
        chk("wrap_pre", 32'(wr_count), 32'hFFFF);
        tick(); chk("wrap", 32'(wr_count), 32'h0000);
        idle_all();
        tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
